// File: rtl/if_id_queue_pkg.sv
// Shared constants and types for the fetch-to-decode instruction queue.
package if_id_queue_pkg;

    localparam int unsigned REG_BUS   = 64;
    localparam int unsigned IFQ_DEPTH = 4;
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;

    typedef struct packed {
        logic [REG_BUS-1:0] pc;
        logic [31:0]        inst;
    } ifq_entry_t;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_PUSH,
        OP_POP,
        OP_BOTH,
        OP_FLUSH
    } ifq_op_e;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
interface if_id_queue_if;
    import if_id_queue_pkg::*;

    logic               if_valid;
    logic [REG_BUS-1:0] if_pc;
    logic [31:0]        if_inst;
    logic               if_ready;
    logic               id_valid;
    logic [REG_BUS-1:0] id_pc;
    logic [31:0]        id_inst;
    logic               id_ready;

    modport master (
        output if_valid, if_pc, if_inst, id_ready,
        input  if_ready, id_valid, id_pc, id_inst
    );

    modport slave (
        input  if_valid, if_pc, if_inst, id_ready,
        output if_ready, id_valid, id_pc, id_inst
    );

endinterface

// File: rtl/if_id_queue.sv
// In-order instruction queue between fetch and decode; flush drops all
// buffered entries and any same-cycle push.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    if_id_queue_if.slave   bus,
    output logic [PTR_W:0] count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    ifq_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic       if_ready;
    logic       id_valid;
    logic       push;
    logic       pop;
    logic       wr_en;
    ifq_entry_t wr_entry;
    ifq_op_e    op;

    // Ready depends only on registered state and reset, never on id_ready.
    assign if_ready = rst & (count_q != FULL_CNT);
    assign id_valid = (count_q != '0);

    always_comb begin
        push = bus.if_valid & if_ready & ~flush;
        pop  = id_valid & bus.id_ready & ~flush;
        op   = OP_HOLD;
        if (flush) begin
            op = OP_FLUSH;
        end else begin
            unique case ({push, pop})
                2'b10:   op = OP_PUSH;
                2'b01:   op = OP_POP;
                2'b11:   op = OP_BOTH;
                default: op = OP_HOLD;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_en    = 1'b0;
        wr_entry = '{pc: bus.if_pc, inst: bus.if_inst};
        unique case (op)
            OP_PUSH: begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
            OP_POP: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
            OP_BOTH: begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            OP_FLUSH: begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                count_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign bus.if_ready = if_ready;
    assign bus.id_valid = id_valid;
    assign bus.id_pc    = id_valid ? mem_q[rd_ptr_q].pc   : '0;
    assign bus.id_inst  = id_valid ? mem_q[rd_ptr_q].inst : INST_NOP;
    assign count        = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ref_ent_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic [PTR_W:0] count;

    if_id_queue_if bus();

    if_id_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus),
        .count(count)
    );

    always #5 clk = ~clk;

    ref_ent_t model[$];
    int  n_cmp = 0;
    int  n_err = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks DUT outputs between edges, then advances the model to
    // what the next posedge should produce.
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_ready;
            exp_ready = rst && (model.size() != DEPTH);
            chk("count", 64'(count), 64'(model.size()));
            chk("if_ready", 64'(bus.if_ready), 64'(exp_ready));
            chk("id_valid", 64'(bus.id_valid), 64'(model.size() != 0));
            if (model.size() != 0) begin
                chk("id_pc", bus.id_pc, model[0].pc);
                chk("id_inst", 64'(bus.id_inst), 64'(model[0].inst));
            end else begin
                chk("id_pc_empty", bus.id_pc, 64'h0);
                chk("id_inst_empty", 64'(bus.id_inst), 64'(INST_NOP));
            end
            if (!rst || flush) begin
                model.delete();
            end else begin
                if (model.size() != 0 && bus.id_ready)
                    void'(model.pop_front());
                if (bus.if_valid && exp_ready)
                    model.push_back('{pc: bus.if_pc, inst: bus.if_inst});
            end
        end
    end

    task automatic cyc(input logic fl, input logic v, input logic [63:0] pc,
                       input logic [31:0] inst, input logic rdy);
        flush        = fl;
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_inst  = inst;
        bus.id_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst          = 1'b0;
        flush        = 1'b0;
        bus.if_valid = 1'b1;
        bus.if_pc    = 64'h8000_0000;
        bus.if_inst  = 32'h0010_0093;
        bus.id_ready = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc(1'b0, 1'b1, 64'h8000_0000, 32'h0010_0093, 1'b0);
        rst = 1'b1;

        // Fill to full, then a refused fifth push
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b1, 64'h8000_0000 + 64'(4 * k), 32'h0010_0093 + 32'(k), 1'b0);
        cyc(1'b0, 1'b1, 64'h8000_0010, 32'h0010_0097, 1'b0);

        // Drain in order
        for (int k = 0; k < 5; k++)
            cyc(1'b0, 1'b0, 64'h0, 32'h0, 1'b1);

        // Streaming with pointer wrap
        for (int k = 0; k < 20; k++)
            cyc(1'b0, 1'b1, 64'h8000_0000 + 64'(4 * k), 32'h0020_0093 + 32'(k), 1'b1);
        cyc(1'b0, 1'b0, 64'h0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 64'h0, 32'h0, 1'b1);

        // Flush with a same-cycle push
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b1, 64'h8000_0040 + 64'(4 * k), 32'h0030_0093 + 32'(k), 1'b0);
        cyc(1'b1, 1'b1, 64'h8000_0100, 32'h0040_0093, 1'b1);
        cyc(1'b0, 1'b1, 64'h8000_0200, 32'h0050_0093, 1'b0);
        cyc(1'b0, 1'b0, 64'h0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 64'h0, 32'h0, 1'b0);

        // Full with simultaneous pop: push refused
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b1, 64'h8000_0300 + 64'(4 * k), 32'h0060_0093 + 32'(k), 1'b0);
        cyc(1'b0, 1'b1, 64'h8000_0400, 32'h0070_0093, 1'b1);
        cyc(1'b0, 1'b0, 64'h0, 32'h0, 1'b0);

        // Reset mid-stream, then first push lands cleanly
        rst = 1'b0;
        cyc(1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 64'h8000_0500, 32'h0080_0093, 1'b0);
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b0, 64'h0, 32'h0, 1'b1);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            logic [63:0] rpc;
            rpc = {$urandom, $urandom};
            cyc($urandom_range(15, 0) == 0, $urandom_range(1, 0) == 1, rpc,
                $urandom, $urandom_range(2, 0) != 0);
        end
        for (int k = 0; k < 6; k++)
            cyc(1'b0, 1'b0, 64'h0, 32'h0, 1'b1);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
